jtkcpu_busarb: RTL

Bus arbiter that shares the JTKCPU external 24-bit memory bus between the CPU core and one DMA requester (sprite/palette copy engine). It halts the CPU through its `halt` input, waits a fixed drain period, grants the bus to DMA, and enforces a maximum DMA burst and a minimum CPU window. It also routes the memory ready strobe back as `dtack` to whichever master owns the bus. It sits between `jtkcpu` and the board memory controller.

---
 rtl/jtkcpu_pkg.sv | 22 ++
 rtl/jtkcpu_busarb_cnt.sv | 35 +++
 rtl/jtkcpu_busarb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the JTKCPU bus arbiter: state encoding, default
// parameter values and the counter width helper.
package jtkcpu_pkg;

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_HALTING = 2'd1,
        ST_DMA     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_st_t;

    localparam int HALT_DLY_DEF  = 4;
    localparam int MAX_BURST_DEF = 64;
    localparam int MIN_CPU_DEF   = 8;

    // Width needed to hold 0..maxv; never narrower than one bit so that a
    // zero-valued parameter still yields a legal vector.
    function automatic int cnt_w(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/jtkcpu_busarb_cnt.sv
// cen-qualified up counter with clear-to-zero, saturation at MAXV and a
// terminal-count flag (cnt == MAXV).
module jtkcpu_busarb_cnt #(
    parameter int W    = 4,
    parameter int MAXV = 8,
    parameter int RSTV = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cen,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [W-1:0] MAXW = W'(MAXV);
    localparam logic [W-1:0] RSTW = W'(RSTV);

    logic [W-1:0] cnt;

    // Clear wins over increment; increment stops at MAXV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RSTW;
        end else if (cen) begin
            if (clr)
                cnt <= '0;
            else if (inc && cnt != MAXW)
                cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == MAXW);

endmodule

// File: rtl/jtkcpu_busarb.sv
// Arbiter sharing the JTKCPU 24-bit memory bus between the CPU and one DMA
// requester. The CPU is halted, a fixed drain period elapses, then DMA gets
// the bus for a bounded burst followed by a one-tick dead cycle and a
// guaranteed CPU window.
module jtkcpu_busarb
    import jtkcpu_pkg::*;
#(
    parameter int HALT_DLY  = HALT_DLY_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int MIN_CPU   = MIN_CPU_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_halt,
    output logic        cpu_dtack,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [23:0] dma_addr,
    input  logic [7:0]  dma_dout,
    input  logic        dma_we,
    output logic        dma_dtack,
    output logic [23:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        bus_cs,
    input  logic        bus_ok
);

    arb_st_t st, st_nxt;
    logic    guard_tc, halt_tc, burst_tc;
    logic    own_cpu, own_dma;

    // Guard: starts satisfied out of reset, restarts from zero when the bus
    // comes back from DMA, and is left alone by an aborted halt.
    jtkcpu_busarb_cnt #(
        .W    (cnt_w(MIN_CPU)),
        .MAXV (MIN_CPU),
        .RSTV (MIN_CPU)
    ) u_guard (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .clr   (st == ST_RELEASE),
        .inc   (st == ST_CPU),
        .tc    (guard_tc)
    );

    // Halt drain counter: held at zero outside HALTING, so it is zero on entry.
    jtkcpu_busarb_cnt #(
        .W    (cnt_w(HALT_DLY)),
        .MAXV (HALT_DLY - 1),
        .RSTV (0)
    ) u_halt (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .clr   (st != ST_HALTING),
        .inc   (st == ST_HALTING),
        .tc    (halt_tc)
    );

    // Burst length counter: held at zero outside DMA.
    jtkcpu_busarb_cnt #(
        .W    (cnt_w(MAX_BURST)),
        .MAXV (MAX_BURST - 1),
        .RSTV (0)
    ) u_burst (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .clr   (st != ST_DMA),
        .inc   (st == ST_DMA),
        .tc    (burst_tc)
    );

    // State register, advancing only on cen ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= ST_CPU;
        else if (cen)
            st <= st_nxt;
    end

    // Next-state logic; a dropped request in HALTING takes priority over
    // the drain finishing.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_CPU:     if (dma_req && guard_tc) st_nxt = ST_HALTING;
            ST_HALTING: begin
                if (!dma_req)
                    st_nxt = ST_CPU;
                else if (halt_tc)
                    st_nxt = ST_DMA;
            end
            ST_DMA:     if (!dma_req || burst_tc) st_nxt = ST_RELEASE;
            ST_RELEASE: st_nxt = ST_CPU;
            default:    st_nxt = ST_CPU;
        endcase
    end

    // Bus muxes decoded from the state register. In RELEASE nobody owns the
    // bus; the address/data keep showing the (halted, hence static) CPU values.
    always_comb begin
        own_cpu   = (st == ST_CPU) || (st == ST_HALTING);
        own_dma   = (st == ST_DMA);
        cpu_halt  = (st != ST_CPU);
        dma_gnt   = own_dma;
        bus_cs    = own_cpu || own_dma;
        bus_addr  = own_dma ? dma_addr : cpu_addr;
        bus_dout  = own_dma ? dma_dout : cpu_dout;
        bus_we    = own_dma ? dma_we : (own_cpu & cpu_we);
        cpu_dtack = bus_ok & own_cpu;
        dma_dtack = bus_ok & own_dma;
    end

endmodule
